// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM encodings, grant owner codes
// and requester indices.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_CMD   = 2'd1,
      ARB_WDATA = 2'd2,
      ARB_RDATA = 2'd3
   } arb_state_e;

   // Owner codes as stored in the round-robin last-grant flop.
   localparam logic GNT_IC = 1'b0;
   localparam logic GNT_DC = 1'b1;

   // Bit positions of each requester in the request/grant vectors.
   localparam int unsigned REQ_IC = 0;
   localparam int unsigned REQ_DC = 1;

   function automatic int unsigned cnt_width(input int unsigned beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; a tie goes to the requester not granted last.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_c
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_c = req_i;
      if (req_i[REQ_IC] && req_i[REQ_DC]) begin
         gnt_c = 2'b00;
         if (last_q == GNT_IC) begin
            gnt_c[REQ_DC] = 1'b1;
         end else begin
            gnt_c[REQ_IC] = 1'b1;
         end
      end
   end

   // GNT_DC is 1, so the DC grant bit is directly the new owner code.
   assign last_d = (advance_i && (gnt_c != 2'b00)) ? gnt_c[REQ_DC] : last_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= GNT_IC;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache line fills and dcache fills and
// write-backs; one latched transaction at a time, sequenced beat by beat.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned BEATS      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ic_req_valid,
   input  logic [ADDR_WIDTH-1:0] ic_req_addr,
   output logic                  ic_req_ready,
   output logic                  ic_resp_valid,
   output logic [DATA_WIDTH-1:0] ic_resp_data,
   input  logic                  dc_req_valid,
   input  logic                  dc_req_rnw,
   input  logic [ADDR_WIDTH-1:0] dc_req_addr,
   output logic                  dc_req_ready,
   input  logic                  dc_wdata_valid,
   input  logic [DATA_WIDTH-1:0] dc_wdata,
   output logic                  dc_wdata_ready,
   output logic                  dc_resp_valid,
   output logic [DATA_WIDTH-1:0] dc_resp_data,
   output logic                  mem_req_valid,
   output logic                  mem_req_rnw,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   output logic                  mem_wdata_valid,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_wdata_ready,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   output logic                  grant_ic,
   output logic                  grant_dc,
   output logic                  busy,
   output logic                  err_resp
);

   localparam int unsigned        CNT_W     = cnt_width(BEATS);
   localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);

   arb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rnw_q, rnw_d;
   logic [1:0]            gnt_q, gnt_d;
   logic                  err_q, err_d;
   logic [1:0]            pick_c;
   logic                  advance;
   logic                  beat;

   rr_arb2 u_rr (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_i     ({dc_req_valid, ic_req_valid}),
      .advance_i (advance),
      .gnt_c     (pick_c)
   );

   // Next-state, latch and beat sequencing; data-path steering is combinational.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      addr_d          = addr_q;
      rnw_d           = rnw_q;
      gnt_d           = gnt_q;
      err_d           = err_q;
      advance         = 1'b0;
      beat            = 1'b0;
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      mem_wdata_valid = 1'b0;
      dc_wdata_ready  = 1'b0;
      ic_resp_valid   = 1'b0;
      dc_resp_valid   = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (pick_c != 2'b00) begin
               advance = 1'b1;
               // Ready is forced low while reset is held, even though it is combinational.
               ic_req_ready = reset_n & pick_c[REQ_IC];
               dc_req_ready = reset_n & pick_c[REQ_DC];
               addr_d  = pick_c[REQ_DC] ? dc_req_addr : ic_req_addr;
               rnw_d   = pick_c[REQ_DC] ? dc_req_rnw : 1'b1;
               gnt_d   = pick_c;
               state_d = ARB_CMD;
            end
         end
         ARB_CMD: begin
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = rnw_q ? ARB_RDATA : ARB_WDATA;
            end
         end
         ARB_WDATA: begin
            mem_wdata_valid = dc_wdata_valid;
            dc_wdata_ready  = mem_wdata_ready;
            beat            = dc_wdata_valid & mem_wdata_ready;
         end
         ARB_RDATA: begin
            ic_resp_valid = mem_resp_valid & gnt_q[REQ_IC];
            dc_resp_valid = mem_resp_valid & gnt_q[REQ_DC];
            beat          = mem_resp_valid;
         end
         default: state_d = ARB_IDLE;
      endcase

      if (beat) begin
         if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            gnt_d   = 2'b00;
            state_d = ARB_IDLE;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Read beats arriving outside a read burst are dropped and flagged.
      if (mem_resp_valid && (state_q != ARB_RDATA)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rnw_q   <= 1'b0;
         gnt_q   <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rnw_q   <= rnw_d;
         gnt_q   <= gnt_d;
         err_q   <= err_d;
      end
   end

   assign mem_req_valid = (state_q == ARB_CMD);
   assign mem_req_rnw   = rnw_q;
   assign mem_req_addr  = addr_q;
   assign mem_wdata     = dc_wdata;
   assign ic_resp_data  = mem_resp_data;
   assign dc_resp_data  = mem_resp_data;
   assign grant_ic      = gnt_q[REQ_IC];
   assign grant_dc      = gnt_q[REQ_DC];
   assign busy          = (state_q != ARB_IDLE);
   assign err_resp      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: arbitration table, randomized traffic
// against a transaction-level model, and error/reset corner sequences.
module tb_mem_arbiter;

   localparam int unsigned AW = 28;
   localparam int unsigned DW = 128;
   localparam int unsigned NB = 4;
   localparam logic [DW-1:0] WBASE = DW'(32'hA);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ic_req_valid, ic_req_ready, ic_resp_valid;
   logic [AW-1:0] ic_req_addr;
   logic [DW-1:0] ic_resp_data;
   logic          dc_req_valid, dc_req_rnw, dc_req_ready;
   logic [AW-1:0] dc_req_addr;
   logic          dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
   logic [DW-1:0] dc_wdata, dc_resp_data;
   logic          mem_req_valid, mem_req_rnw, mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
   logic [DW-1:0] mem_wdata, mem_resp_data;
   logic          grant_ic, grant_dc, busy, err_resp;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) dut (
      .clk(clk), .reset_n(reset_n),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
      .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
      .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready), .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata),
      .mem_wdata_ready(mem_wdata_ready), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data), .grant_ic(grant_ic), .grant_dc(grant_dc),
      .busy(busy), .err_resp(err_resp)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit last_dc = 1'b0;   // model: dcache won the most recent arbitration

   typedef struct {
      bit icv; bit dcv; bit rnw; int stall; int sm; bit exp_ic; bit exp_dc;
   } vec_t;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_rnw = 0; dc_req_addr = '0;
      dc_wdata_valid = 0; dc_wdata = '0; mem_req_ready = 0; mem_wdata_ready = 0;
      mem_resp_valid = 0; mem_resp_data = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      last_dc = 1'b0;
   endtask

   // One arbitration attempt; if granted, the transaction is run to completion.
   // sm: 0 = memory always ready, 1 = ready toggles, 2 = random handshakes.
   task automatic do_txn(input bit icv, input bit dcv, input bit rnw, input int stall_in,
                         input int sm, input bit exp_ic, input bit exp_dc,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da);
      bit win_dc, exp_rnw, in_cmd, tg, wv, rd;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] rdata;
      int stall, k, cyc;
      @(posedge clk); #1;
      ic_req_valid = icv; ic_req_addr = ia;
      dc_req_valid = dcv; dc_req_rnw = rnw; dc_req_addr = da;
      dc_wdata_valid = 0; mem_req_ready = 0; mem_wdata_ready = 0; mem_resp_valid = 0;
      @(negedge clk);
      chk("idle_busy", DW'(busy), '0);
      chk("idle_grants", DW'({grant_ic, grant_dc}), '0);
      chk("ic_req_ready", DW'(ic_req_ready), DW'(exp_ic));
      chk("dc_req_ready", DW'(dc_req_ready), DW'(exp_dc));
      if (!exp_ic && !exp_dc) return;
      win_dc  = exp_dc;
      last_dc = exp_dc;
      exp_a   = win_dc ? da : ia;
      exp_rnw = win_dc ? rnw : 1'b1;
      in_cmd = 1; tg = 0; k = 0; cyc = 0; stall = stall_in;
      while (k < NB && cyc < 200) begin
         @(posedge clk); #1; cyc++;
         if (win_dc) dc_req_valid = 0; else ic_req_valid = 0;
         mem_resp_valid = 0; wv = 0; rd = 0;
         if (in_cmd) begin
            mem_req_ready = (stall == 0);
            if (stall > 0) stall--;
            dc_wdata_valid = 1; mem_wdata_ready = 1; dc_wdata = '1;
         end else begin
            mem_req_ready = 0; tg = ~tg;
            wv = (sm == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
            rd = (sm == 0) ? 1'b1 : (sm == 1) ? tg : 1'($urandom_range(1, 0));
            if (exp_rnw) begin
               dc_wdata_valid = 0; mem_wdata_ready = 0;
               rdata = {$urandom, $urandom, $urandom, $urandom};
               mem_resp_valid = rd; mem_resp_data = rdata;
            end else begin
               dc_wdata_valid = wv; mem_wdata_ready = rd; dc_wdata = WBASE + DW'(k);
            end
         end
         @(negedge clk);
         chk("no_ready_while_busy", DW'({ic_req_ready, dc_req_ready}), '0);
         chk("busy", DW'(busy), DW'(1'b1));
         chk("grants", DW'({grant_ic, grant_dc}), DW'({~win_dc, win_dc}));
         if (in_cmd) begin
            chk("cmd_valid", DW'(mem_req_valid), DW'(1'b1));
            chk("cmd_addr", DW'(mem_req_addr), DW'(exp_a));
            chk("cmd_rnw", DW'(mem_req_rnw), DW'(exp_rnw));
            chk("cmd_no_wbeat", DW'({mem_wdata_valid, dc_wdata_ready}), '0);
            chk("cmd_no_resp", DW'({ic_resp_valid, dc_resp_valid}), '0);
            if (mem_req_ready) in_cmd = 0;
         end else begin
            chk("data_cmd_off", DW'(mem_req_valid), '0);
            if (!exp_rnw) begin
               chk("wdata_valid", DW'(mem_wdata_valid), DW'(wv));
               chk("wdata_ready", DW'(dc_wdata_ready), DW'(rd));
               chk("w_no_resp", DW'({ic_resp_valid, dc_resp_valid}), '0);
               if (wv && rd) begin
                  chk("wdata_beat", mem_wdata, WBASE + DW'(k));
                  k++;
               end
            end else begin
               chk("ic_resp_valid", DW'(ic_resp_valid), DW'(rd & ~win_dc));
               chk("dc_resp_valid", DW'(dc_resp_valid), DW'(rd & win_dc));
               if (rd) begin
                  chk("resp_data", win_dc ? dc_resp_data : ic_resp_data, rdata);
                  k++;
               end
            end
         end
      end
      if (k < NB) chk("txn_timeout_beats", DW'(k), DW'(NB));
   endtask

   vec_t tbl[10];
   bit icv, dcv, xdc;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1, 1, 1, 5, 0, 0, 1};   // tie out of reset: dcache, cmd stalled 5 cycles
      tbl[1] = '{1, 1, 1, 0, 0, 1, 0};   // tie again: icache
      tbl[2] = '{1, 1, 0, 0, 1, 0, 1};   // dcache write 0xA..0xD, ready toggling
      tbl[3] = '{1, 1, 1, 0, 0, 1, 0};
      tbl[4] = '{1, 0, 1, 0, 1, 1, 0};   // icache alone
      tbl[5] = '{0, 1, 0, 0, 0, 0, 1};   // dcache write alone
      tbl[6] = '{0, 0, 1, 0, 0, 0, 0};   // nobody requests
      tbl[7] = '{1, 1, 1, 0, 2, 1, 0};
      tbl[8] = '{0, 1, 1, 0, 0, 0, 1};   // dcache read at 0x123, memory always ready
      tbl[9] = '{0, 1, 1, 2, 2, 0, 1};

      do_reset();
      chk("rst_busy", DW'(busy), '0);
      chk("rst_grants", DW'({grant_ic, grant_dc}), '0);
      chk("rst_mem_valids", DW'({mem_req_valid, mem_wdata_valid}), '0);
      chk("rst_readies", DW'({ic_req_ready, dc_req_ready, dc_wdata_ready}), '0);
      chk("rst_resp_valids", DW'({ic_resp_valid, dc_resp_valid}), '0);
      chk("rst_err", DW'(err_resp), '0);

      foreach (tbl[i])
         do_txn(tbl[i].icv, tbl[i].dcv, tbl[i].rnw, tbl[i].stall, tbl[i].sm,
                tbl[i].exp_ic, tbl[i].exp_dc, AW'(32'h0ABCDEF), AW'(32'h0000123));

      // Random traffic; the model decides the winner from the round-robin rule.
      for (int i = 0; i < 40; i++) begin
         icv = 1'($urandom_range(1, 0));
         dcv = 1'($urandom_range(1, 0));
         xdc = dcv && (!icv || !last_dc);
         do_txn(icv, dcv, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 2,
                icv && !xdc, xdc, AW'($urandom), AW'($urandom));
      end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("post_random_idle", DW'(busy), '0);
      chk("no_err_normal", DW'(err_resp), '0);

      // Stray read beat in IDLE: dropped and flagged sticky until reset.
      @(posedge clk); #1;
      mem_resp_valid = 1; mem_resp_data = '1;
      @(negedge clk);
      chk("stray_not_routed", DW'({ic_resp_valid, dc_resp_valid}), '0);
      @(posedge clk); #1;
      mem_resp_valid = 0;
      @(negedge clk);
      chk("err_set", DW'(err_resp), DW'(1'b1));
      repeat (3) @(negedge clk);
      chk("err_sticky", DW'(err_resp), DW'(1'b1));
      do_reset();
      chk("err_cleared", DW'(err_resp), '0);

      // Reset asserted during beat 2 of a dcache read.
      @(posedge clk); #1;
      dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = AW'(32'h0000456);
      @(posedge clk); #1;
      dc_req_valid = 0; mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0; mem_resp_valid = 1;
      @(negedge clk);
      chk("midrst_beat1", DW'(dc_resp_valid), DW'(1'b1));
      @(posedge clk); #1;
      ic_req_valid = 1; dc_wdata_valid = 1; mem_wdata_ready = 1;
      reset_n = 0;
      #1;
      chk("midrst_busy", DW'(busy), '0);
      chk("midrst_grants", DW'({grant_ic, grant_dc}), '0);
      chk("midrst_resp", DW'({ic_resp_valid, dc_resp_valid}), '0);
      chk("midrst_ready", DW'({ic_req_ready, dc_req_ready, dc_wdata_ready}), '0);
      chk("midrst_mem", DW'({mem_req_valid, mem_wdata_valid}), '0);
      chk("midrst_err", DW'(err_resp), '0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      reset_n = 1; last_dc = 0;
      do_txn(1, 0, 1, 1, 0, 1, 0, AW'(32'h0FEDCBA), '0);
      do_txn(1, 1, 1, 0, 0, 0, 1, AW'(32'h0000777), AW'(32'h0000888));
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("final_idle", DW'(busy), '0);
      chk("final_err", DW'(err_resp), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
